mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning the bus address width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have ports if_req, input, 1 bit (fetch read request) and if_addr, input, ADDR_W bits (fetch address).
REQ-005 The module SHALL have ports if_rdata, output, 32 bits (fetched word) and if_stallreq, output, 1 bit (fetch stall request to the pipeline controller).
REQ-006 The module SHALL have ports mem_req, input, 1 bit; mem_we, input, 1 bit (1 = write); mem_sel, input, 4 bits (byte enables); mem_addr, input, ADDR_W bits; mem_wdata, input, 32 bits.
REQ-007 The module SHALL have ports mem_rdata, output, 32 bits (load data) and mem_stallreq, output, 1 bit (mem-stage stall request).
REQ-008 The module SHALL have bus-side outputs bus_ce (1), bus_we (1), bus_sel (4), bus_addr (ADDR_W) and bus_wdata (32), all registered.
REQ-009 The module SHALL have bus-side inputs bus_ack, 1 bit (transfer complete), and bus_rdata, 32 bits (valid when bus_ack=1).

Function
REQ-010 The FSM SHALL have exactly five states: IDLE, IF_WAIT, MEM_WAIT, IF_DONE and MEM_DONE.
REQ-011 In IDLE with mem_req=1, the next state SHALL be MEM_WAIT, with bus_ce=1, bus_we=mem_we, bus_sel=mem_sel, bus_addr=mem_addr and bus_wdata=mem_wdata registered.
REQ-012 In IDLE with mem_req=0 and if_req=1, the next state SHALL be IF_WAIT, with bus_ce=1, bus_we=0, bus_sel=4'b1111 and bus_addr=if_addr registered.
REQ-013 When mem_req and if_req are asserted in the same IDLE cycle, mem SHALL win; if is served in a later IDLE cycle.
REQ-014 In X_WAIT, all bus outputs SHALL hold stable until bus_ack=1 is sampled, with no timeout.
REQ-015 On bus_ack=1 in IF_WAIT, if_rdata SHALL load bus_rdata, bus_ce SHALL clear, and the next state SHALL be IF_DONE.
REQ-016 On bus_ack=1 in MEM_WAIT, the next state SHALL be MEM_DONE and bus_ce SHALL clear; mem_rdata SHALL load bus_rdata only when the transfer was a read (bus_we=0).
REQ-017 IF_DONE and MEM_DONE SHALL last exactly one cycle, then return to IDLE; no new request is accepted in a DONE state.
REQ-018 if_stallreq SHALL be combinational: if_req AND NOT (state == IF_DONE).
REQ-019 mem_stallreq SHALL be combinational: mem_req AND NOT (state == MEM_DONE).
REQ-020 Minimum access latency SHALL be: request in cycle N (IDLE), bus_ce=1 in N+1, ack at earliest in N+1, DONE in N+2 with stallreq low, IDLE in N+3.
REQ-021 A request dropped during X_WAIT SHALL not abort the transfer; the transfer completes and the DONE state still occurs, with its result captured but unused.
REQ-022 bus_ack=1 in IDLE or a DONE state SHALL be ignored, leaving no state or data change.
REQ-023 if_rdata and mem_rdata SHALL hold their last captured value until the next capture.

Reset
REQ-024 While rst=1 at a rising edge, state SHALL become IDLE and bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata and mem_rdata SHALL all become 0.
REQ-025 Reset asserted during X_WAIT SHALL abandon the transfer immediately; a bus_ack arriving after reset SHALL be ignored per REQ-022.
REQ-026 With rst=1, the stallreq outputs SHALL still follow REQ-018/019 combinationally, since state is IDLE.

Verification
REQ-027 Fetch read: if_req=1, if_addr=0x0000_0100, ack in 2nd WAIT cycle, bus_rdata=0x2402_0005 -> bus_addr=0x100, if_stallreq high 3 cycles then low 1 cycle, if_rdata=0x2402_0005.
REQ-028 Simultaneous requests: if_req=1, mem_req=1, mem_we=0, mem_addr=0x80 -> MEM_WAIT first, bus_addr=0x80; after MEM_DONE, fetch issued; if_stallreq high throughout the mem transfer.
REQ-029 Store: mem_we=1, mem_sel=4'b0011, mem_wdata=0xDEAD_BEEF -> bus_we=1, bus_sel=0x3, bus_wdata=0xDEAD_BEEF, mem_rdata unchanged after ack.
REQ-030 Zero-wait ack: bus_ack tied 1 -> each access takes exactly 3 cycles (IDLE, WAIT, DONE); back-to-back fetches give one stall-free cycle per 3.
REQ-031 Reset mid-transfer: rst=1 in MEM_WAIT, then bus_ack=1 the next cycle -> state IDLE, bus_ce=0, mem_rdata=0, ack ignored.
REQ-032 Dropped request: if_req deasserted during IF_WAIT -> transfer completes, IF_DONE occurs, if_stallreq stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-transfer bus.
// Mem has priority; each access walks IDLE -> X_WAIT -> X_DONE -> IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_stallreq,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_stallreq,
  output logic              bus_ce,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [2:0] {IDLE, IF_WAIT, MEM_WAIT, IF_DONE, MEM_DONE} state_e;

  state_e            state_q, state_d;
  logic              bus_ce_q, bus_ce_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  always_comb begin
    state_d     = state_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d     = MEM_WAIT;
          bus_ce_d    = 1'b1;
          bus_we_d    = mem_we;
          bus_sel_d   = mem_sel;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
        end else if (if_req) begin
          // Fetch leaves bus_wdata as-is; it is a don't-care for reads.
          state_d    = IF_WAIT;
          bus_ce_d   = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = 4'b1111;
          bus_addr_d = if_addr;
        end
      end
      IF_WAIT: begin
        if (bus_ack) begin
          state_d    = IF_DONE;
          bus_ce_d   = 1'b0;
          if_rdata_d = bus_rdata;
        end
      end
      MEM_WAIT: begin
        if (bus_ack) begin
          state_d  = MEM_DONE;
          bus_ce_d = 1'b0;
          if (!bus_we_q) mem_rdata_d = bus_rdata;
        end
      end
      IF_DONE, MEM_DONE: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Stall drops only in the DONE cycle, so the pipeline advances exactly once.
  assign if_stallreq  = if_req  && (state_q != IF_DONE);
  assign mem_stallreq = mem_req && (state_q != MEM_DONE);

  assign bus_ce    = bus_ce_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule
